// File: rtl/deserializer_pkg.sv
// Shared types and defaults for the serial-to-parallel frame receiver.
package deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/deserializer.sv
// MSB-first frame deserializer with a one-deep output holding register,
// a self-test signature compare, and overflow/abort reporting.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             serial_in,
  input  logic             data_ready,
  input  logic [WIDTH-1:0] exp_data,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             match,
  output logic             overflow,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("deserializer: WIDTH must be at least 2");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  // Only WIDTH-1 bits are stored: the final bit is taken straight from
  // serial_in on the completing edge.
  logic [WIDTH-2:0] sreg;
  logic [WIDTH-1:0] word;
  logic             done;

  assign word = {sreg, serial_in};
  assign done = (state == SHIFT) && !start && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      match      <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            sreg  <= (WIDTH-1)'(serial_in);
            cnt   <= CW'(WIDTH - 2);
          end
        end
        SHIFT: begin
          // A strobe mid-frame wins over completion, even on the bit-0 edge.
          if (start) begin
            frame_err <= 1'b1;
            sreg      <= (WIDTH-1)'(serial_in);
            cnt       <= CW'(WIDTH - 2);
          end else begin
            sreg <= word[WIDTH-2:0];
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (done) begin
        if (!data_valid || data_ready) begin
          data_out   <= word;
          match      <= (word == exp_data);
          data_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboarded bench: expected words are queued as frames are driven and
// retired whenever the consumer handshake takes data_out.
module tb_deserializer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         serial_in = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] exp_data = '0;
  logic [W-1:0] data_out;
  logic         data_valid, match, overflow, frame_err, busy;

  deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .serial_in(serial_in),
    .data_ready(data_ready), .exp_data(exp_data), .data_out(data_out),
    .data_valid(data_valid), .match(match), .overflow(overflow),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         m;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Retire one expected word per accepted handshake.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underrun", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", 64'(data_out), 64'(e.d));
        chk("sb_match", 64'(match), 64'(e.m));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the top nbits of word MSB first, start on the MSB; optionally
  // raise data_ready only during the bit-0 cycle.
  task automatic drive_bits(input logic [W-1:0] word, input int nbits, input bit rdy_last);
    for (int i = W - 1; i >= W - nbits; i--) begin
      start     = (i == W - 1);
      serial_in = word[i];
      if (rdy_last) data_ready = (i == 0);
      tick();
    end
    start     = 1'b0;
    serial_in = 1'b0;
    if (rdy_last) data_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out", 64'(data_out), 64'd0);
    chk("rst_flags", 64'({data_valid, match, overflow, frame_err, busy}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // matching signature, consumer always ready
    data_ready = 1'b1;
    exp_data   = 32'hA5A50F3C;
    sb.push_back('{32'hA5A50F3C, 1'b1});
    drive_bits(32'hA5A50F3C, W, 1'b0);
    chk("lat_valid", 64'(data_valid), 64'd1);
    chk("lat_data", 64'(data_out), 64'hA5A50F3C);
    chk("lat_busy", 64'(busy), 64'd0);
    tick();
    chk("accept_clr", 64'(data_valid), 64'd0);

    // signature mismatch
    exp_data = 32'hA5A50F3D;
    sb.push_back('{32'hA5A50F3C, 1'b0});
    drive_bits(32'hA5A50F3C, W, 1'b0);
    chk("nm_valid", 64'(data_valid), 64'd1);
    chk("nm_match", 64'(match), 64'd0);
    tick();

    // overflow: second word dropped while the first is held
    data_ready = 1'b0;
    exp_data   = 32'h00000001;
    sb.push_back('{32'h00000001, 1'b1});
    drive_bits(32'h00000001, W, 1'b0);
    chk("busy_idle", 64'(busy), 64'd0);
    drive_bits(32'hFFFFFFFF, W, 1'b0);
    chk("ovf_data", 64'(data_out), 64'h00000001);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_valid", 64'(data_valid), 64'd1);
    chk("ovf_match", 64'(match), 64'd1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("ovf_drain", 64'(data_valid), 64'd0);
    tick();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    do_reset();
    chk("ovf_rst", 64'(overflow), 64'd0);

    // accept and complete in the same cycle: new word loads, no overflow
    exp_data = 32'h00000001;
    sb.push_back('{32'h00000001, 1'b1});
    drive_bits(32'h00000001, W, 1'b0);
    exp_data = 32'hFFFFFFFF;
    sb.push_back('{32'hFFFFFFFF, 1'b1});
    drive_bits(32'hFFFFFFFF, W, 1'b1);
    chk("same_data", 64'(data_out), 64'hFFFFFFFF);
    chk("same_valid", 64'(data_valid), 64'd1);
    chk("same_ovf", 64'(overflow), 64'd0);
    data_ready = 1'b1;
    tick();
    chk("same_drain", 64'(data_valid), 64'd0);

    // restart mid-frame at cycle 10
    exp_data = 32'h12345678;
    sb.push_back('{32'h12345678, 1'b1});
    drive_bits(32'hCAFEF00D, 10, 1'b0);
    chk("ab_fe_pre", 64'(frame_err), 64'd0);
    begin
      logic [W-1:0] w;
      w = 32'h12345678;
      start     = 1'b1;
      serial_in = w[31];
      tick();
      chk("ab_fe_11", 64'(frame_err), 64'd1);
      start     = 1'b0;
      serial_in = w[30];
      tick();
      chk("ab_fe_12", 64'(frame_err), 64'd0);
      chk("ab_busy", 64'(busy), 64'd1);
      for (int i = 29; i >= 0; i--) begin
        serial_in = w[i];
        if (i == 0) chk("ab_nodone", 64'(data_valid), 64'd0);
        tick();
      end
      serial_in = 1'b0;
    end
    chk("ab_data", 64'(data_out), 64'h12345678);
    chk("ab_valid", 64'(data_valid), 64'd1);
    tick();

    // asynchronous reset mid-frame, then a clean frame
    data_ready = 1'b0;
    exp_data   = 32'h0BADF00D;
    sb.push_back('{32'h0BADF00D, 1'b1});
    drive_bits(32'h0BADF00D, W, 1'b0);
    sb.delete();
    drive_bits(32'h55555555, 15, 1'b0);
    chk("mid_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", 64'(data_out), 64'd0);
    chk("arst_flags", 64'({data_valid, match, overflow, frame_err, busy}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("arst_fe", 64'(frame_err), 64'd0);
    data_ready = 1'b1;
    exp_data   = 32'hDEADBEEF;
    sb.push_back('{32'hDEADBEEF, 1'b1});
    drive_bits(32'hDEADBEEF, W, 1'b0);
    chk("post_data", 64'(data_out), 64'hDEADBEEF);
    chk("post_valid", 64'(data_valid), 64'd1);
    tick();
    tick();

    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, frame length in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  frame strobe; high in the cycle serial_in carries the frame MSB (bit WIDTH-1).
REQ-005 SHALL have port: serial_in  input  1  serial data, MSB first, one bit per cycle.
REQ-006 SHALL have port: data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-007 SHALL have port: exp_data  input  WIDTH  expected self-test signature, sampled at frame completion.
REQ-008 SHALL have port: data_out  output  WIDTH  last completed word.
REQ-009 SHALL have port: data_valid  output  1  data_out holds an unaccepted word.
REQ-010 SHALL have port: match  output  1  data_out == exp_data at capture; qualified by data_valid.
REQ-011 SHALL have port: overflow  output  1  sticky; a completed word was dropped.
REQ-012 SHALL have port: frame_err  output  1  one-cycle pulse; frame aborted by a restart.
REQ-013 SHALL have port: busy  output  1  high while in SHIFT.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT.
REQ-015 IDLE: start=1 SHALL sample serial_in as bit WIDTH-1, load bit counter with WIDTH-2 and go to SHIFT; start=0 ignores serial_in.
REQ-016 SHIFT: each cycle SHALL shift serial_in into the LSB of the shift register (left shift) and decrement the counter.
REQ-017 On the edge sampling bit 0, the FSM SHALL return to IDLE and the full word SHALL be a completion event.
REQ-018 Latency: start in cycle T SHALL give data_valid=1 and the word on data_out in cycle T+WIDTH.
REQ-019 Completion with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle, SHALL load data_out and match, and set data_valid=1.
REQ-020 Completion with data_valid=1 and data_ready=0 SHALL drop the new word, keep data_out/match unchanged and set overflow.
REQ-021 data_valid SHALL clear on data_valid & data_ready with no simultaneous completion.
REQ-022 start=1 while in SHIFT (including the bit-0 cycle) SHALL abort the frame without a completion event, pulse frame_err for one cycle and restart per REQ-015 using the current serial_in.
REQ-023 Shift register and counter SHALL be separate from data_out, so a new frame can shift while data_valid is held.
REQ-024 Counter width SHALL be $clog2(WIDTH); WIDTH SHALL be at least 2.
REQ-025 match SHALL be registered and computed from the completed word and exp_data in the completion cycle.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, counter 0, shift register 0, data_out 0, data_valid 0, match 0, overflow 0, frame_err 0, busy 0.
REQ-027 Reset mid-frame SHALL discard the partial word with no completion event or frame_err.
REQ-028 Once set, overflow SHALL clear only on rst.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (IDLE, SHIFT) and the default frame-width constant 32.
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 start at cycle 0, serial 0xA5A50F3C MSB first, data_ready=1, exp_data=0xA5A50F3C -> cycle 32: data_valid=1, data_out=0xA5A50F3C, match=1; data_valid=0 at cycle 33.
REQ-032 Same frame with exp_data=0xA5A50F3D -> cycle 32: data_valid=1, match=0.
REQ-033 data_ready=0; frames 0x00000001 then 0xFFFFFFFF back-to-back -> cycle 64: data_out=0x00000001, overflow=1, data_valid=1.
REQ-034 data_valid=1 held; data_ready=1 exactly in the second frame's completion cycle -> data_out=0xFFFFFFFF, data_valid=1, overflow=0.
REQ-035 start at cycle 0, start again at cycle 10 with frame 0x12345678 -> frame_err=1 in cycle 11 only; cycle 42: data_out=0x12345678.
REQ-036 rst=1 at cycle 15 of a frame -> all outputs 0 immediately; next start-aligned frame 0xDEADBEEF is received correctly.
